gba_bus_arbiter: RTL and testbench
==================================

// Module: gba_bus_arbiter
// PURPOSE
//  Shares the single GBA system bus (memory/MMU port) between the ARM7 CPU and the DMA engine.
//  Sits between the CPU/DMA bus masters and the MMU.
//  Arbitrates per transaction: DMA has fixed priority, with a starvation guard for the CPU.
//  Forwards one request at a time, holds it until the MMU signals ready, then returns a one-cycle ack plus read data.
// PARAMETERS
//  ADDR_W     32  address width of every port
//  DATA_W     32  data width of every port
//  DMA_MAX    4   max consecutive DMA grants while CPU waits (1..15); then CPU is granted once
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       asynchronous, active-high reset
//  cpu_req     in   1       CPU request; held with its fields stable until cpu_ack
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_we      in   1       CPU write enable
//  cpu_size    in   2       CPU access size: 0 byte, 1 half, 2 word (3 is treated as word)
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_ack     out  1       one-cycle completion pulse to CPU
//  cpu_rdata   out  DATA_W  read data, valid while cpu_ack=1
//  dma_req     in   1       DMA request; same handshake rules as CPU
//  dma_addr    in   ADDR_W  DMA address
//  dma_we      in   1       DMA write enable
//  dma_size    in   2       DMA access size
//  dma_wdata   in   DATA_W  DMA write data
//  dma_lock    in   1       DMA keeps the bus across back-to-back transfers (bypasses DMA_MAX)
//  dma_ack     out  1       one-cycle completion pulse to DMA
//  dma_rdata   out  DATA_W  read data, valid while dma_ack=1
//  mem_req     out  1       request to MMU, held until mem_ready
//  mem_addr    out  ADDR_W  registered address of the granted master
//  mem_we      out  1       registered write enable
//  mem_size    out  2       registered size (3 forwarded as 2)
//  mem_wdata   out  DATA_W  registered write data
//  mem_ready   in   1       MMU completes the access in a cycle where mem_req=1
//  mem_rdata   in   DATA_W  MMU read data, valid with mem_ready
//  owner       out  2       0 none, 1 CPU, 2 DMA (debug/DMA status)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; starve_cnt=0.
//  FSM states: IDLE, XFER, DONE.
//  IDLE, arbitration order:
//   - DMA wins if dma_req=1, unless cpu_req=1 and starve_cnt==DMA_MAX and dma_lock=0.
//   - Otherwise CPU wins if cpu_req=1.
//   - Otherwise stay in IDLE.
//  On grant: latch the winner's fields into mem_* regs, set mem_req=1, set owner, go to XFER.
//   mem_req is therefore first high the cycle after the grant decision.
//  XFER: mem_* fields stay constant.
//   - mem_ready=0: remain in XFER (wait states are unbounded).
//   - mem_ready=1: latch mem_rdata (reads only; writes return 0), drop mem_req, pulse the owner's ack next cycle, go to DONE.
//  DONE (1 cycle): owner ack=1 with rdata; owner->0; go to IDLE.
//   - Min latency: req (rising edge N) -> mem_req at N+1; ready at N+1 -> ack at N+2; next grant decided at N+3.
//   - Requester must drop or change req in the cycle after ack. A req still high in IDLE is a new transaction.
//  Starvation counter (saturating, 0..DMA_MAX):
//   - Incremented on each DMA grant made while cpu_req=1.
//   - Cleared on any CPU grant, or when cpu_req=0 at a DMA grant.
//   - With dma_lock=1 the counter is frozen and DMA always wins.
//  Requests that drop before being granted are ignored; no ack is generated.
//  A master is never granted twice concurrently; at most one mem transaction is outstanding.
//  Simultaneous mem_ready and new requests: the new request is sampled only in IDLE.
//  Reset mid-transfer: immediate return to IDLE with outputs cleared; no ack is issued for the aborted access.
// TESTING
//  1 CPU read alone, mem_ready same cycle as mem_req, mem_rdata=0xDEADBEEF
//    -> cpu_ack 2 cycles after req, cpu_rdata=0xDEADBEEF, owner 1->0.
//  2 cpu_req and dma_req both high from IDLE -> DMA first (owner=2); CPU served next; both acked exactly once.
//  3 Both request continuously, DMA_MAX=4, dma_lock=0
//    -> grant sequence D,D,D,D,C,D,D,D,D,C...; no gaps beyond IDLE/DONE.
//  4 Same as 3 with dma_lock=1 -> DMA only, CPU never granted; release lock -> CPU granted at the next arbitration.
//  5 DMA write addr=0x0600_0000 wdata=0x1234, size=1, mem_ready after 5 wait cycles
//    -> mem_* stable all 5 cycles, dma_ack once, dma_rdata=0.
//  6 Assert reset during XFER -> mem_req=0 and owner=0 immediately (async); no ack; post-reset CPU read completes normally.

Source files
------------

// File: rtl/gba_bus_arbiter.sv
// gba_bus_arbiter
// Shares the single GBA system bus (MMU port) between the ARM7 CPU and the
// DMA engine. One transaction is outstanding at a time: a winner is picked in
// IDLE, its request is registered onto the mem_* port and held until
// mem_ready, and the owner then receives a one-cycle ack with the read data.
// DMA has fixed priority; a saturating starvation counter forces one CPU
// grant after DMA_MAX consecutive DMA grants made while the CPU was waiting,
// unless the DMA holds the bus with dma_lock.
module gba_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DMA_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU master
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  // DMA master
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [1:0]        dma_size,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  // MMU port
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic [1:0]        owner
);

  // FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // owner encoding
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  // saturation point of the starvation counter (DMA_MAX is 1..15)
  localparam logic [3:0] STARVE_MAX = 4'(DMA_MAX);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [3:0]        starve_cnt;

  logic              cpu_starved;
  logic              grant_dma;
  logic              grant_cpu;
  logic              take_grant;
  logic              finish;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] resp_data;

  // Arbitration: DMA wins unless the CPU has been passed over DMA_MAX times
  // and the DMA is not holding the bus with dma_lock.
  always_comb begin
    cpu_starved = cpu_req && (starve_cnt == STARVE_MAX) && !dma_lock;
    grant_dma   = dma_req && !cpu_starved;
    grant_cpu   = cpu_req && !grant_dma;
  end

  // Grant / completion strobes; requests are only sampled in IDLE.
  always_comb begin
    take_grant = (state == IDLE) && (grant_dma || grant_cpu);
    finish     = (state == XFER) && mem_ready;
  end

  // Field mux for the winning master; size 3 is forwarded as a word access.
  always_comb begin
    if (grant_dma) begin
      sel_addr  = dma_addr;
      sel_we    = dma_we;
      sel_size  = (dma_size == 2'd3) ? 2'd2 : dma_size;
      sel_wdata = dma_wdata;
    end else begin
      sel_addr  = cpu_addr;
      sel_we    = cpu_we;
      sel_size  = (cpu_size == 2'd3) ? 2'd2 : cpu_size;
      sel_wdata = cpu_wdata;
    end
  end

  // Writes return zero data to the master; reads return the MMU data.
  always_comb begin
    resp_data = mem_we ? '0 : mem_rdata;
  end

  // Next-state logic: IDLE -> XFER on grant, XFER -> DONE on mem_ready,
  // DONE lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_grant) state_next = XFER;
      XFER:    if (mem_ready)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // mem_req: raised on grant, held through wait states, dropped on ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req <= 1'b0;
    end else if (take_grant) begin
      mem_req <= 1'b1;
    end else if (finish) begin
      mem_req <= 1'b0;
    end
  end

  // Registered request fields; loaded only at grant so they stay constant
  // for the whole transfer regardless of what the masters do meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_size  <= 2'd0;
      mem_wdata <= '0;
    end else if (take_grant) begin
      mem_addr  <= sel_addr;
      mem_we    <= sel_we;
      mem_size  <= sel_size;
      mem_wdata <= sel_wdata;
    end
  end

  // Owner tracking: set at grant, cleared when the DONE cycle ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= OWN_NONE;
    end else if (take_grant) begin
      owner <= grant_dma ? OWN_DMA : OWN_CPU;
    end else if (state == DONE) begin
      owner <= OWN_NONE;
    end
  end

  // CPU response: one-cycle ack with data during DONE, zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else if (finish && (owner == OWN_CPU)) begin
      cpu_ack   <= 1'b1;
      cpu_rdata <= resp_data;
    end else begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end
  end

  // DMA response: one-cycle ack with data during DONE, zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
    end else if (finish && (owner == OWN_DMA)) begin
      dma_ack   <= 1'b1;
      dma_rdata <= resp_data;
    end else begin
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
    end
  end

  // Starvation counter: counts DMA grants that overtook a waiting CPU,
  // saturates at DMA_MAX, clears on a CPU grant or an uncontested DMA grant,
  // and is frozen while the DMA holds the bus with dma_lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (take_grant) begin
      if (grant_dma) begin
        if (!dma_lock) begin
          if (!cpu_req) begin
            starve_cnt <= 4'd0;
          end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_gba_bus_arbiter.sv
// tb_gba_bus_arbiter
// Directed bench for gba_bus_arbiter: a behavioural MMU with programmable
// wait states, a monitor logging grants and acks, and hand-computed
// expectations for each scenario.
module tb_gba_bus_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int DMAX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_we = 1'b0;
  logic [1:0]    cpu_size = 2'd0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic          dma_we = 1'b0;
  logic [1:0]    dma_size = 2'd0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_lock = 1'b0;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [1:0]    mem_size;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  gba_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DMA_MAX(DMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_size(dma_size),
    .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural MMU: answers after wait_cfg wait cycles with rdata_cfg.
  int            wait_cfg  = 0;
  int            wcnt      = 0;
  logic [DW-1:0] rdata_cfg = '0;

  always @(negedge clk) begin
    if (mem_req && !reset) begin
      if (wcnt >= wait_cfg) begin
        mem_ready = 1'b1;
        mem_rdata = rdata_cfg;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      wcnt = 0;
    end
  end

  // Monitor: one line per grant and per ack.
  int            cyc = 0;
  int            cpu_acks = 0;
  int            dma_acks = 0;
  int            grants[$];
  int            gcyc[$];
  logic [AW-1:0] gaddr[$];
  logic [DW-1:0] last_cpu_rdata = '0;
  logic [DW-1:0] last_dma_rdata = '0;
  logic [1:0]    prev_owner = 2'd0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (owner != 2'd0 && prev_owner == 2'd0) begin
      grants.push_back(int'(owner));
      gcyc.push_back(cyc);
      gaddr.push_back(mem_addr);
      $display("grant owner=%0d addr=%h we=%0d size=%0d cyc=%0d", owner, mem_addr, mem_we, mem_size, cyc);
    end
    if (cpu_ack) begin
      cpu_acks++;
      last_cpu_rdata = cpu_rdata;
      $display("cpu ack rdata=%h cyc=%0d", cpu_rdata, cyc);
    end
    if (dma_ack) begin
      dma_acks++;
      last_dma_rdata = dma_rdata;
      $display("dma ack rdata=%h cyc=%0d", dma_rdata, cyc);
    end
    prev_owner = owner;
  end

  function automatic int get_grant(input int i);
    return (i < grants.size()) ? grants[i] : 0;
  endfunction

  function automatic int get_gcyc(input int i);
    return (i < gcyc.size()) ? gcyc[i] : 0;
  endfunction

  function automatic logic [AW-1:0] get_gaddr(input int i);
    return (i < gaddr.size()) ? gaddr[i] : '0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int k = 0;
    while (grants.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(grants.size() >= n), 64'd1);
  endtask

  // Hold requests until acked, dropping each in the ack cycle.
  task automatic serve(input int budget, input string tag);
    int k = 0;
    while ((cpu_req || dma_req) && k < budget) begin
      @(negedge clk);
      if (cpu_ack) cpu_req = 1'b0;
      if (dma_ack) dma_req = 1'b0;
      k++;
    end
    check(tag, 64'({cpu_req, dma_req}), 64'd0);
    @(negedge clk);
  endtask

  // Pack grants [base, base+n) into 2-bit fields, first grant most significant.
  function automatic logic [31:0] grant_seq(input int base, input int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s = {s[29:0], 2'(get_grant(base + i))};
    return s;
  endfunction

  initial begin
    int g0;
    int a0;
    int b0;
    int k;

    // Reset state
    do_reset();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_acks", 64'({cpu_ack, dma_ack}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);

    // 1: CPU read alone, zero wait states
    wait_cfg = 0; rdata_cfg = 32'hDEADBEEF;
    cpu_addr = 32'h0200_0040; cpu_we = 1'b0; cpu_size = 2'd2; cpu_req = 1'b1;
    @(negedge clk);
    check("t1_owner_grant", 64'(owner), 64'd1);
    check("t1_mem_req", 64'(mem_req), 64'd1);
    check("t1_mem_addr", 64'(mem_addr), 64'h0200_0040);
    check("t1_no_early_ack", 64'(cpu_ack), 64'd0);
    @(negedge clk);
    check("t1_ack", 64'(cpu_ack), 64'd1);
    check("t1_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    check("t1_mem_req_drop", 64'(mem_req), 64'd0);
    check("t1_owner_done", 64'(owner), 64'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    check("t1_ack_pulse", 64'(cpu_ack), 64'd0);
    check("t1_owner_idle", 64'(owner), 64'd0);

    // 2: simultaneous requests -> DMA first, then CPU, one ack each
    do_reset();
    rdata_cfg = 32'h5555_AAAA;
    g0 = grants.size(); a0 = cpu_acks; b0 = dma_acks;
    cpu_addr = 32'h0300_0100; cpu_we = 1'b0; cpu_size = 2'd2;
    dma_addr = 32'h0200_0800; dma_we = 1'b0; dma_size = 2'd2;
    cpu_req = 1'b1; dma_req = 1'b1;
    serve(40, "t2_timeout");
    check("t2_first", 64'(get_grant(g0)), 64'd2);
    check("t2_second", 64'(get_grant(g0 + 1)), 64'd1);
    check("t2_first_addr", 64'(get_gaddr(g0)), 64'h0200_0800);
    check("t2_cpu_acks", 64'(cpu_acks - a0), 64'd1);
    check("t2_dma_acks", 64'(dma_acks - b0), 64'd1);
    check("t2_cpu_rdata", 64'(last_cpu_rdata), 64'h5555_AAAA);

    // 3: continuous contention, no lock -> D,D,D,D,C repeating, 3 cycles apart
    do_reset();
    g0 = grants.size();
    cpu_req = 1'b1; dma_req = 1'b1;
    wait_grants(g0 + 10, 100, "t3_timeout");
    check("t3_sequence", 64'(grant_seq(g0, 10)), 64'hAA6A9);
    check("t3_spacing", 64'(get_gcyc(g0 + 9) - get_gcyc(g0)), 64'd27);
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (6) @(negedge clk);

    // 4: reach the starvation limit, then lock: DMA keeps winning; unlock -> CPU
    do_reset();
    g0 = grants.size();
    cpu_req = 1'b1; dma_req = 1'b1;
    wait_grants(g0 + 4, 40, "t4_pre_timeout");
    dma_lock = 1'b1;
    wait_grants(g0 + 10, 60, "t4_lock_timeout");
    check("t4_lock_sequence", 64'(grant_seq(g0, 10)), 64'hAAAAA);
    dma_lock = 1'b0;
    wait_grants(g0 + 11, 20, "t4_unlock_timeout");
    check("t4_cpu_after_unlock", 64'(get_grant(g0 + 10)), 64'd1);
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (6) @(negedge clk);

    // 5: DMA halfword write with 5 wait states
    do_reset();
    wait_cfg = 5; rdata_cfg = 32'hFFFF_FFFF;
    b0 = dma_acks;
    dma_addr = 32'h0600_0000; dma_wdata = 32'h0000_1234; dma_size = 2'd1; dma_we = 1'b1;
    dma_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_ctl%0d", i), 64'({mem_req, mem_we, mem_size}), 64'b1101);
      check($sformatf("t5_addr%0d", i), 64'(mem_addr), 64'h0600_0000);
      check($sformatf("t5_wdata%0d", i), 64'(mem_wdata), 64'h0000_1234);
      check($sformatf("t5_noack%0d", i), 64'(dma_ack), 64'd0);
      @(negedge clk);
    end
    @(negedge clk);
    check("t5_ack", 64'(dma_ack), 64'd1);
    check("t5_rdata_zero", 64'(dma_rdata), 64'd0);
    dma_req = 1'b0;
    @(negedge clk);
    check("t5_ack_once", 64'(dma_acks - b0), 64'd1);
    check("t5_ack_pulse", 64'(dma_ack), 64'd0);

    // 6: reset during XFER, then a normal CPU read (size 3 forwarded as 2)
    do_reset();
    wait_cfg = 10; rdata_cfg = 32'h1111_2222;
    cpu_addr = 32'h0300_0000; cpu_we = 1'b0; cpu_size = 2'd2; cpu_req = 1'b1;
    k = 0;
    while (!mem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("t6_started", 64'(mem_req), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_async_mem_req", 64'(mem_req), 64'd0);
    check("t6_async_owner", 64'(owner), 64'd0);
    cpu_req = 1'b0;
    a0 = cpu_acks;
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("t6_no_ack", 64'(cpu_acks - a0), 64'd0);
    wait_cfg = 1; rdata_cfg = 32'hCAFE_F00D;
    cpu_addr = 32'h0300_0010; cpu_size = 2'd3; cpu_req = 1'b1;
    @(negedge clk);
    check("t6_mem_req", 64'(mem_req), 64'd1);
    check("t6_size_fwd", 64'(mem_size), 64'd2);
    serve(20, "t6_timeout");
    check("t6_acks", 64'(cpu_acks - a0), 64'd1);
    check("t6_rdata", 64'(last_cpu_rdata), 64'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
